// File: rtl/acc_job_scheduler_if.sv
// -----------------------------------------------------------------------------
// acc_job_scheduler_if
// Host-to-scheduler job submission channel (valid/ready handshake).
//   job_valid        host presents a job
//   job_ready        scheduler can accept a job this cycle
//   job_instruction  job opcode word, 0 = NOP (rejected by the scheduler)
//   job_offset       job RAM base address
//   job_filesize     job length in words
// master = host side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface acc_job_scheduler_if;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_instruction;
  logic [31:0] job_offset;
  logic [31:0] job_filesize;

  modport master (
    output job_valid,
    output job_instruction,
    output job_offset,
    output job_filesize,
    input  job_ready
  );

  modport slave (
    input  job_valid,
    input  job_instruction,
    input  job_offset,
    input  job_filesize,
    output job_ready
  );
endinterface

// File: rtl/acc_job_scheduler.sv
// -----------------------------------------------------------------------------
// acc_job_scheduler
// Job queue and sequencer in front of dc_router_top. Host jobs are buffered in
// a DEPTH-entry FIFO and issued one at a time on instruction/offset/filesize.
// A job ends when acc_done rises or the watchdog expires; the router is then
// returned to NOP and the next job waits until acc_done has fallen.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   job          job submission channel (slave side)
//   acc_done     level from router PLA, high when the active job is complete
//   instruction  to router instruction input (0 = NOP)
//   offset       to router offset input
//   filesize     to router filesize input
//   busy         high while a job is running or being cleared
//   job_done     one-cycle pulse on normal completion
//   job_timeout  one-cycle pulse on watchdog abort
//   job_reject   one-cycle pulse when a NOP job is accepted and discarded
//   queue_count  number of jobs stored in the FIFO
// -----------------------------------------------------------------------------
module acc_job_scheduler #(
  parameter int          PTR_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  acc_job_scheduler_if.slave    job,
  input  logic                  acc_done,
  output logic [31:0]           instruction,
  output logic [31:0]           offset,
  output logic [31:0]           filesize,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_timeout,
  output logic                  job_reject,
  output logic [PTR_W:0]        queue_count
);

  localparam int              DEPTH     = 1 << PTR_W;
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]  CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [31:0]     WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [95:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg, count_next;
  logic [31:0]       wdog_reg, wdog_next;
  logic [31:0]       instr_reg, instr_next;
  logic [31:0]       offset_reg, offset_next;
  logic [31:0]       filesize_reg, filesize_next;
  logic              busy_reg, done_reg, timeout_reg, reject_reg;
  logic              done_next, timeout_next;
  logic              ready, handshake, push, pop;
  logic [95:0]       head_job;

  // Ready looks only at the stored count, so a full queue stays closed even
  // in a cycle where the head is being popped.
  assign ready         = (count_reg < DEPTH_CNT);
  assign job.job_ready = ready;
  assign handshake     = job.job_valid & ready;
  assign push          = handshake & (job.job_instruction != 32'd0);
  assign head_job      = fifo_mem[rd_ptr_reg];

  always_comb begin
    state_next    = state_reg;
    wdog_next     = wdog_reg;
    instr_next    = instr_reg;
    offset_next   = offset_reg;
    filesize_next = filesize_reg;
    done_next     = 1'b0;
    timeout_next  = 1'b0;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_next = 32'd0;
        if (count_reg != '0) begin
          pop           = 1'b1;
          instr_next    = head_job[95:64];
          offset_next   = head_job[63:32];
          filesize_next = head_job[31:0];
          wdog_next     = 32'd0;
          state_next    = RUN;
        end
      end
      RUN: begin
        // Completion wins over the watchdog when both land on the same edge.
        if (acc_done) begin
          state_next = CLEAR;
          done_next  = 1'b1;
          instr_next = 32'd0;
        end else if (wdog_reg == WDOG_LAST) begin
          state_next   = CLEAR;
          timeout_next = 1'b1;
          instr_next   = 32'd0;
        end else begin
          wdog_next = wdog_reg + 32'd1;
        end
      end
      CLEAR: begin
        instr_next = 32'd0;
        if (!acc_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + CNT_ONE;
    else if (!push && pop) count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wdog_reg     <= 32'd0;
      instr_reg    <= 32'd0;
      offset_reg   <= 32'd0;
      filesize_reg <= 32'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      reject_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      wdog_reg     <= wdog_next;
      instr_reg    <= instr_next;
      offset_reg   <= offset_next;
      filesize_reg <= filesize_next;
      busy_reg     <= (state_next != IDLE);
      done_reg     <= done_next;
      timeout_reg  <= timeout_next;
      reject_reg   <= handshake & (job.job_instruction == 32'd0);
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {job.job_instruction, job.job_offset, job.job_filesize};
  end

  assign instruction = instr_reg;
  assign offset      = offset_reg;
  assign filesize    = filesize_reg;
  assign busy        = busy_reg;
  assign job_done    = done_reg;
  assign job_timeout = timeout_reg;
  assign job_reject  = reject_reg;
  assign queue_count = count_reg;

endmodule

// File: tb/tb_acc_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_acc_job_scheduler
// Randomized bench for acc_job_scheduler. The host driver pushes jobs, a router
// responder raises acc_done after a per-job delay (looked up by offset) and
// records the outcome it expects in a scoreboard queue. A monitor runs a
// job-level reference model (list of waiting jobs, "running since N cycles",
// "waiting for acc_done to fall") and compares every output once per cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acc_job_scheduler;
  localparam int PTR_W = 2;
  localparam int DEPTH = 4;
  localparam int T     = 12;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] off;
    logic [31:0] size;
  } job_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           acc_done = 1'b0;
  logic [31:0]    instruction, offset, filesize;
  logic           busy, job_done, job_timeout, job_reject;
  logic [PTR_W:0] queue_count;

  acc_job_scheduler_if jif();

  acc_job_scheduler #(.PTR_W(PTR_W), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .job         (jif.slave),
    .acc_done    (acc_done),
    .instruction (instruction),
    .offset      (offset),
    .filesize    (filesize),
    .busy        (busy),
    .job_done    (job_done),
    .job_timeout (job_timeout),
    .job_reject  (job_reject),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  job_t model_q[$];
  int   outcome_q[$];              // 1 = done expected, 2 = timeout expected
  int   delay_of[logic [31:0]];
  int   hold_of[logic [31:0]];
  int   resp_mode = 0;
  job_t cur = '0;
  logic m_running = 1'b0;
  logic m_clear = 1'b0;
  int   m_j = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  task automatic monitor_step();
    logic fire, exp_done, exp_to, exp_rej;
    job_t nj;
    int   oc;
    if (!reset) begin
      model_q.delete();
      m_running = 1'b0;
      m_clear   = 1'b0;
      cur       = '0;
      chk("rst_instruction", instruction, 32'd0);
      chk("rst_offset", offset, 32'd0);
      chk("rst_filesize", filesize, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_pulses", {job_done, job_timeout, job_reject}, 32'd0);
      chk("rst_queue_count", queue_count, 32'd0);
      return;
    end
    fire     = jif.job_valid && (model_q.size() < DEPTH);
    exp_rej  = fire && (jif.job_instruction == 32'd0);
    exp_done = 1'b0;
    exp_to   = 1'b0;
    if (m_running) begin
      m_j++;
      if (acc_done) begin
        exp_done = 1'b1; m_running = 1'b0; m_clear = 1'b1;
      end else if (m_j == T) begin
        exp_to = 1'b1; m_running = 1'b0; m_clear = 1'b1;
      end
    end else if (m_clear) begin
      if (!acc_done) m_clear = 1'b0;
    end else if (model_q.size() > 0) begin
      cur       = model_q.pop_front();
      m_running = 1'b1;
      m_j       = 0;
      $display("issue instr=%08h offset=%08h filesize=%08h t=%0t", cur.instr, cur.off, cur.size, $time);
    end
    if (fire && jif.job_instruction != 32'd0) begin
      nj.instr = jif.job_instruction;
      nj.off   = jif.job_offset;
      nj.size  = jif.job_filesize;
      model_q.push_back(nj);
    end
    if (exp_rej) $display("reject offset=%08h t=%0t", jif.job_offset, $time);
    chk("busy", busy, m_running || m_clear);
    chk("instruction", instruction, m_running ? cur.instr : 32'd0);
    chk("offset", offset, cur.off);
    chk("filesize", filesize, cur.size);
    chk("queue_count", queue_count, model_q.size());
    chk("job_ready", jif.job_ready, model_q.size() < DEPTH);
    chk("job_done", job_done, exp_done);
    chk("job_timeout", job_timeout, exp_to);
    chk("job_reject", job_reject, exp_rej);
    if (job_done || job_timeout) begin
      $display("complete offset=%08h kind=%s t=%0t", offset, job_timeout ? "timeout" : "done", $time);
      if (outcome_q.size() == 0) begin
        total++; bad++;
        $display("FAIL outcome_unexpected actual=%0d required=none t=%0t", job_timeout ? 2 : 1, $time);
      end else begin
        oc = outcome_q.pop_front();
        chk("outcome_kind", job_timeout ? 32'd2 : 32'd1, oc);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    monitor_step();
  end

  // ---------------- router responder ----------------
  int   resp_d, resp_h, raise_in, hold_left;
  logic prev_b = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      acc_done  = 1'b0;
      resp_mode = 0;
      outcome_q.delete();
      prev_b    = 1'b0;
    end else begin
      if (resp_mode == 0 && busy && !prev_b) begin
        resp_d = delay_of.exists(offset) ? delay_of[offset] : 0;
        resp_h = hold_of.exists(offset) ? hold_of[offset] : 0;
        // acc_done raised d negedges after issue is sampled d+1 edges into
        // RUN; the watchdog fires on edge T, and done wins on that edge.
        if (resp_d <= T - 1) begin
          outcome_q.push_back(1); raise_in = resp_d; resp_mode = 1;
        end else begin
          outcome_q.push_back(2); resp_mode = 3;
        end
      end
      if (resp_mode == 1) begin
        if (raise_in == 0) begin acc_done = 1'b1; resp_mode = 2; end
        else raise_in--;
      end else if (resp_mode == 2 && (job_done || job_timeout)) begin
        resp_mode = 4; hold_left = resp_h;
      end else if (resp_mode == 3 && (job_done || job_timeout)) begin
        resp_mode = 0;
      end
      if (resp_mode == 4) begin
        if (hold_left == 0) begin acc_done = 1'b0; resp_mode = 0; end
        else hold_left--;
      end
      prev_b = busy;
    end
  end

  // ---------------- host driver ----------------
  task automatic push_job(input logic [31:0] ins, input logic [31:0] off,
                          input logic [31:0] sz, input int d, input int h);
    int n = 0;
    delay_of[off] = d;
    hold_of[off]  = h;
    jif.job_valid       = 1'b1;
    jif.job_instruction = ins;
    jif.job_offset      = off;
    jif.job_filesize    = sz;
    while (!jif.job_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL push_wait actual=blocked required=accepted t=%0t", $time);
    end
    @(negedge clk);
    jif.job_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    int ok = 0;
    while (ok < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (!busy && queue_count == 0 && resp_mode == 0 && !acc_done) ok++;
      else ok = 0;
    end
    if (ok < 3) begin
      total++; bad++;
      $display("FAIL idle_wait actual=busy required=idle t=%0t", $time);
    end
  endtask

  logic [31:0] off_ctr = 32'h1000;

  task automatic next_off(output logic [31:0] o);
    o = off_ctr;
    off_ctr = off_ctr + 32'h40;
  endtask

  initial begin
    logic [31:0] o, ins;
    int n, r, d;
    jif.job_valid = 1'b0;
    jif.job_instruction = 32'd0;
    jif.job_offset = 32'd0;
    jif.job_filesize = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single job, done 10 cycles into RUN
    push_job(32'd1, 32'h100, 32'd16, 10, 0);
    wait_idle();

    // back-to-back behind a long job: queue fills, 5th waits for a pop
    next_off(o); push_job(32'h11, o, 32'd7, T + 2, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      next_off(o);
      push_job(32'h20 + i, o, 32'd100 + i, i, 1);
      if (i == 3) chk("full_ready", jif.job_ready, 32'd0);
    end
    wait_idle();

    // reject at idle and while busy
    next_off(o); push_job(32'd0, o, 32'd5, 0, 0);
    next_off(o); push_job(32'h33, o, 32'd9, 4, 0);
    next_off(o); push_job(32'd0, o, 32'd5, 0, 0);
    wait_idle();

    // watchdog: timeout, same-cycle done, late timeout, then normal
    next_off(o); push_job(32'h41, o, 32'd1, T, 0);
    next_off(o); push_job(32'h42, o, 32'd2, T - 1, 0);
    next_off(o); push_job(32'h43, o, 32'd3, T + 4, 0);
    next_off(o); push_job(32'h44, o, 32'd4, 2, 0);
    wait_idle();

    // sticky acc_done held after completion, next job queued behind it
    next_off(o); push_job(32'h51, o, 32'd8, 3, 5);
    next_off(o); push_job(32'h52, o, 32'd8, 1, 0);
    wait_idle();

    // reset while running with three jobs queued
    for (int i = 0; i < 4; i++) begin
      next_off(o);
      push_job(32'h60 + i, o, 32'd20, T + 2, 0);
    end
    n = 0;
    while (!(busy && queue_count == 3) && n < 20) begin @(negedge clk); n++; end
    chk("pre_reset_count", queue_count, 32'd3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_idle", busy, 32'd0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      next_off(o);
      ins = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom() | 32'h1);
      r = $urandom_range(0, 9);
      d = (r == 0) ? T - 1 : (r == 1) ? T : $urandom_range(0, T + 3);
      push_job(ins, o, $urandom(), d, $urandom_range(0, 4));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute guard against a hung run
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished t=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
